// File: rtl/muladdsub9x9wide_acc_seq.sv
// Packet accumulator sequencer around an external combinational MULTADDSUB9X9WIDE.
// Optional beat-count output m_beats is enabled by defining MAS_SEQ_BEATCNT_EN.
//
// state | meaning
// IDLE  | no partial packet; next accepted beat is a packet's first (C = 0)
// ACCUM | partial packet held in acc; C = acc, signedness from pkt_signed
module muladdsub9x9wide_acc_seq #(
  parameter int MAX_BEATS = 0,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_signed,
  input  logic              clear,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [35:0]       s_a,
  input  logic [35:0]       s_b,
  input  logic [3:0]        s_addsub,
  input  logic              s_last,
  output logic [35:0]       dsp_a,
  output logic [35:0]       dsp_b,
  output logic [3:0]        dsp_addsub,
  output logic              dsp_signed,
  output logic [53:0]       dsp_c,
  output logic              dsp_loadc,
  input  logic [53:0]       dsp_z,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [53:0]       m_data,
  output logic              m_trunc
`ifdef MAS_SEQ_BEATCNT_EN
  ,
  output logic [CNT_W-1:0]  m_beats
`endif
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam bit              LIMIT_EN = (MAX_BEATS != 0);
  localparam logic [CNT_W-1:0] LIMIT   = LIMIT_EN ? CNT_W'(MAX_BEATS - 1) : '0;

  state_t            state;
  state_t            state_nxt;
  logic [53:0]       acc;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              pkt_signed;
  logic              beat;
  logic              limit_hit;
  logic              close;

  assign dsp_a      = s_a;
  assign dsp_b      = s_b;
  assign dsp_addsub = s_addsub;
  assign dsp_loadc  = 1'b1;
  assign cnt_inc    = cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // clear gates s_ready, so it can never coincide with an accepted beat
  always_comb begin
    state_nxt  = state;
    s_ready    = ~clear & (~m_valid | m_ready);
    beat       = s_valid & s_ready;
    limit_hit  = LIMIT_EN && (cnt == LIMIT);
    close      = beat & (s_last | limit_hit);
    dsp_signed = (state == IDLE) ? cfg_signed : pkt_signed;
    dsp_c      = (state == IDLE) ? 54'd0 : acc;
    if (clear)      state_nxt = IDLE;
    else if (close) state_nxt = IDLE;
    else if (beat)  state_nxt = ACCUM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      cnt        <= '0;
      pkt_signed <= 1'b0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (close) begin
      cnt <= '0;
    end else if (beat) begin
      acc <= dsp_z;
      cnt <= cnt_inc;
      if (state == IDLE) pkt_signed <= cfg_signed;
    end
  end

  // a closing beat while the old result drains simply overwrites it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_trunc <= 1'b0;
    end else if (close) begin
      m_valid <= 1'b1;
      m_data  <= dsp_z;
      m_trunc <= ~s_last;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

`ifdef MAS_SEQ_BEATCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     m_beats <= '0;
    else if (close) m_beats <= cnt_inc;
  end
`endif

endmodule
